seg7_dynamic_scanner: RTL and testbench

Converts a static per-digit segment image into a time-multiplexed 7-segment drive: one-hot `digit` strobe plus `hgfedcba` pattern, one digit at a time. It is the counterpart of the block that captures dynamic drive into per-digit registers. Together they let boards with multiplexed displays, and the board-emulation path, share one `hex` array representation. The image is snapshotted once per frame, so the display never tears mid-scan.

---
 rtl/seg7_scan_pkg.sv | 13 +
 rtl/seg7_dynamic_scanner.sv | 121 ++++++++++++
 tb/tb_seg7_dynamic_scanner.sv | 137 +++++++++++++
 3 files changed

// File: rtl/seg7_scan_pkg.sv
// Shared types and sizing helpers for the 7-segment dynamic scanner.
package seg7_scan_pkg;

  typedef enum logic [1:0] {ST_LOAD, ST_BLANK, ST_SHOW} scan_state_t;

  // Dwell counter must hold the longer of the two phase lengths.
  function automatic int cnt_width(input int on_c, input int blank_c);
    int m;
    m = (on_c > blank_c) ? on_c : blank_c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/seg7_dynamic_scanner.sv
// Time-multiplexed 7-segment driver: snapshots a static per-digit image once
// per frame and strobes it out one digit at a time with a dark guard phase.
//
// state    | meaning
// ST_LOAD  | one cycle per frame; image and enables are captured at its end
// ST_BLANK | blank_cycles dark cycles before each digit slot
// ST_SHOW  | on_cycles cycles with digit idx lit (if enabled)
module seg7_dynamic_scanner
  import seg7_scan_pkg::*;
#(
  parameter int w_digit      = 8,
  parameter int w_seg        = 8,
  parameter int on_cycles    = 1000,
  parameter int blank_cycles = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [w_digit-1:0][w_seg-1:0]   hex,
  input  logic [w_digit-1:0]              digit_en,
  output logic [w_seg-1:0]                hgfedcba,
  output logic [w_digit-1:0]              digit,
  output logic                            frame_start
);

  localparam int idx_w = (w_digit > 1) ? $clog2(w_digit) : 1;
  localparam int cnt_w = cnt_width(on_cycles, blank_cycles);

  localparam logic [cnt_w-1:0] on_last    = cnt_w'(on_cycles - 1);
  localparam logic [cnt_w-1:0] blank_last = cnt_w'((blank_cycles > 0) ? blank_cycles - 1 : 0);
  localparam logic [idx_w-1:0] idx_last   = idx_w'(w_digit - 1);
  localparam scan_state_t      st_slot    = (blank_cycles > 0) ? ST_BLANK : ST_SHOW;

  if (on_cycles < 1 || w_digit < 1) begin : g_param_check
    $error("seg7_dynamic_scanner: on_cycles and w_digit must both be >= 1");
  end

  scan_state_t                     state, state_nxt;
  logic [idx_w-1:0]                idx, idx_nxt;
  logic [cnt_w-1:0]                cnt, cnt_nxt;
  logic [w_digit-1:0][w_seg-1:0]   snap_hex, snap_hex_nxt;
  logic [w_digit-1:0]              snap_en, snap_en_nxt;
  logic [w_digit-1:0]              digit_nxt;
  logic [w_seg-1:0]                seg_nxt;
  logic                            frame_start_nxt;

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    cnt_nxt      = cnt + cnt_w'(1);
    snap_hex_nxt = snap_hex;
    snap_en_nxt  = snap_en;

    unique case (state)
      ST_LOAD: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        // The reset cycle sits in LOAD with frame_start low; it is not a real
        // frame boundary, so repeat LOAD once to give the frame its marker.
        if (frame_start) begin
          snap_hex_nxt = hex;
          snap_en_nxt  = digit_en;
          state_nxt    = st_slot;
        end
      end
      ST_BLANK: begin
        if (cnt == blank_last) begin
          cnt_nxt   = '0;
          state_nxt = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (cnt == on_last) begin
          cnt_nxt = '0;
          if (idx == idx_last) begin
            state_nxt = ST_LOAD;
          end else begin
            idx_nxt   = idx + idx_w'(1);
            state_nxt = st_slot;
          end
        end
      end
      default: begin
        cnt_nxt   = '0;
        idx_nxt   = '0;
        state_nxt = ST_LOAD;
      end
    endcase

    // Outputs are registered decodes of the state being entered.
    digit_nxt       = '0;
    seg_nxt         = '0;
    frame_start_nxt = (state_nxt == ST_LOAD);
    if (state_nxt == ST_SHOW && snap_en_nxt[idx_nxt]) begin
      digit_nxt = w_digit'(1) << idx_nxt;
      seg_nxt   = snap_hex_nxt[idx_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_LOAD;
      idx         <= '0;
      cnt         <= '0;
      snap_hex    <= '0;
      snap_en     <= '0;
      digit       <= '0;
      hgfedcba    <= '0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cnt         <= cnt_nxt;
      snap_hex    <= snap_hex_nxt;
      snap_en     <= snap_en_nxt;
      digit       <= digit_nxt;
      hgfedcba    <= seg_nxt;
      frame_start <= frame_start_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_dynamic_scanner.sv
// Bench for seg7_dynamic_scanner: two instances (blank phase of 2 and of 0)
// compared every cycle against a frame-position reference model.
module tb_seg7_dynamic_scanner;

  localparam int W  = 4;
  localparam int S  = 8;
  localparam int ON = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [W-1:0][S-1:0]  hex;
  logic [W-1:0]         digit_en;
  logic [S-1:0]         seg_a, seg_b;
  logic [W-1:0]         dig_a, dig_b;
  logic                 fs_a, fs_b;

  seg7_dynamic_scanner #(.w_digit(W), .w_seg(S), .on_cycles(ON), .blank_cycles(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .hex(hex), .digit_en(digit_en),
    .hgfedcba(seg_a), .digit(dig_a), .frame_start(fs_a)
  );

  seg7_dynamic_scanner #(.w_digit(W), .w_seg(S), .on_cycles(ON), .blank_cycles(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .hex(hex), .digit_en(digit_en),
    .hgfedcba(seg_b), .digit(dig_b), .frame_start(fs_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position within frame plus the image captured at LOAD.
  int                  blank_of [2] = '{2, 0};
  int                  k        [2] = '{0, 0};
  bit                  in_rst   [2] = '{1, 1};
  logic [W-1:0][S-1:0] m_hex    [2];
  logic [W-1:0]        m_en     [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void expect_out(input int i, output logic [W-1:0] ed,
                                     output logic [S-1:0] es, output logic efs);
    int j, per, slot;
    ed  = '0;
    es  = '0;
    efs = 1'b0;
    if (in_rst[i]) return;
    if (k[i] == 0) begin
      efs = 1'b1;
      return;
    end
    per  = blank_of[i] + ON;
    j    = k[i] - 1;
    slot = j / per;
    if ((j % per) >= blank_of[i] && m_en[i][slot]) begin
      ed = W'(1) << slot;
      es = m_hex[i][slot];
    end
  endfunction

  task automatic cycle(input logic [W-1:0][S-1:0] hv, input logic [W-1:0] ev, input logic rv);
    logic [W-1:0] ed;
    logic [S-1:0] es;
    logic         efs;
    string        nm;
    hex      = hv;
    digit_en = ev;
    rst_n    = rv;
    for (int i = 0; i < 2; i++)
      if (!in_rst[i] && k[i] == 0) begin
        m_hex[i] = hv;
        m_en[i]  = ev;
      end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rv) in_rst[i] = 1'b1;
      else if (in_rst[i]) begin
        in_rst[i] = 1'b0;
        k[i]      = 0;
      end else k[i] = (k[i] + 1) % (1 + W * (blank_of[i] + ON));
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      expect_out(i, ed, es, efs);
      nm = $sformatf("%s k=%0d rst=%0d", (i == 0) ? "blank2" : "blank0", k[i], in_rst[i]);
      check_val({nm, " digit"},       32'((i == 0) ? dig_a : dig_b), 32'(ed));
      check_val({nm, " hgfedcba"},    32'((i == 0) ? seg_a : seg_b), 32'(es));
      check_val({nm, " frame_start"}, 32'((i == 0) ? fs_a : fs_b),   32'(efs));
      check_val({nm, " onehot0"},     32'($onehot0((i == 0) ? dig_a : dig_b)), 32'd1);
    end
  endtask

  logic [W-1:0][S-1:0] img0, img1, hv;
  logic [W-1:0]        ev;
  logic                rv;

  initial begin
    img0     = {8'h4F, 8'h5B, 8'h06, 8'h3F};
    img1     = img0;
    img1[0]  = 8'h7D;
    rst_n    = 1'b0;
    hex      = img0;
    digit_en = 4'hF;

    repeat (3) cycle(img0, 4'hF, 1'b0);

    // Full scan, then hex[0] changes mid-frame and shows only from the next frame.
    for (int c = 0; c < 42; c++) cycle((c >= 10) ? img1 : img0, 4'hF, 1'b1);

    // Enable mask: disabled digits keep their slot but stay dark.
    for (int c = 0; c < 21; c++) cycle(img1, 4'b1010, 1'b1);

    // Reset in the middle of a digit slot.
    for (int g = 0; g < 40 && k[0] != 14; g++) cycle(img1, 4'hF, 1'b1);
    check_val("reach_k14", 32'(k[0]), 32'd14);
    cycle(img1, 4'hF, 1'b0);
    repeat (30) cycle(img1, 4'hF, 1'b1);

    hv = img0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(3) == 0) hv = $urandom;
      ev = W'($urandom);
      rv = ($urandom_range(149) != 0);
      cycle(hv, ev, rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
